seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 SHALL have port dividend, input, BITWIDTH bits: unsigned numerator.
REQ-007 SHALL have port divisor, input, BITWIDTH bits: unsigned denominator.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port quotient, output, BITWIDTH bits: unsigned quotient.
REQ-011 SHALL have port remainder, output, BITWIDTH bits: unsigned remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the current result came from divisor == 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-015 SHALL accept an operand pair when in_valid && in_ready, latch dividend and divisor, and move IDLE->CALC, or IDLE->DONE if divisor == 0.
REQ-016 SHALL use unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-017 SHALL, on each step, shift the (BITWIDTH+1)-bit partial remainder left and bring in the next dividend bit.
REQ-018 SHALL, on each step, trial-subtract the zero-extended divisor from the partial remainder.
REQ-019 SHALL, on each step, keep the difference and set the quotient bit to 1 if the difference is non-negative, otherwise restore the partial remainder and set the quotient bit to 0.
REQ-020 SHALL use a step counter of width $clog2(BITWIDTH)+1 that runs from 0 to BITWIDTH-1; the state SHALL move CALC->DONE on the edge that completes step BITWIDTH-1.
REQ-021 SHALL have a latency of exactly BITWIDTH+1 cycles from the accept edge to out_valid high (17 cycles for BITWIDTH=16).
REQ-022 SHALL, for divisor == 0, produce quotient = all ones, remainder = dividend and div_by_zero = 1, with out_valid high 1 cycle after accept.
REQ-023 SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE until out_valid && out_ready.
REQ-024 SHALL move DONE->IDLE on the out_valid && out_ready edge; in_ready SHALL be 1 in the following cycle (no same-cycle accept of a new operation).
REQ-025 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-026 SHALL produce a result satisfying dividend == quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
REQ-027 SHALL handle the dividend < divisor, divisor == 1 and all-ones operand cases with no special path.
REQ-028 SHALL drive div_by_zero = 0 for every result with divisor != 0.

Reset
REQ-029 SHALL, on a clk edge with rst_n == 0, enter IDLE and clear the counter, partial remainder, quotient, remainder, div_by_zero and out_valid to 0; in_ready SHALL be 1 after reset.
REQ-030 SHALL discard any operation in progress (CALC or DONE) when reset is applied, and produce no output for it after reset.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, CALC, DONE) and the counter-width function/localparam in a shared package, flexibit_div_pkg.
REQ-032 SHALL implement one restoring iteration (shift, trial subtract, select) as the combinational sub-module div_step, parameterised by BITWIDTH; seq_divider SHALL instantiate it once.
REQ-033 SHALL contain no combinational path from in_valid or out_ready to any output.

Verification
REQ-034 SHALL cover: BITWIDTH=16, dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0, out_valid rising 17 cycles after accept.
REQ-035 SHALL cover: dividend=0x1234, divisor=0 -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1, out_valid 1 cycle after accept.
REQ-036 SHALL cover: dividend=0xFFFF, divisor=0xFFFF -> quotient=1, remainder=0.
REQ-037 SHALL cover: dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-038 SHALL cover: out_ready held low for 10 cycles in DONE -> outputs stable; then out_ready=1 -> IDLE, and in_ready=1 the next cycle.
REQ-039 SHALL cover: rst_n=0 for 1 cycle during step 8 of CALC -> IDLE, in_ready=1, out_valid never asserted for that operation.

Source files
------------

// File: rtl/flexibit_div_pkg.sv
// flexibit_div_pkg: shared FSM state encoding and step-counter sizing for seq_divider
package flexibit_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    function automatic int cnt_w(input int bw);
        return $clog2(bw) + 1;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract, select)
module div_step #(
    parameter int BITWIDTH = 16
) (
    input  logic [BITWIDTH:0]   rem_i,
    input  logic                bit_i,
    input  logic [BITWIDTH-1:0] divisor_i,
    output logic [BITWIDTH:0]   rem_o,
    output logic                q_o
);
    logic [BITWIDTH+1:0] diff;
    // One extra bit so a negative trial difference shows up as the sign bit
    assign diff  = {rem_i, bit_i} - {2'b00, divisor_i};
    assign q_o   = ~diff[BITWIDTH+1];
    assign rem_o = q_o ? diff[BITWIDTH:0] : {rem_i[BITWIDTH-1:0], bit_i};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned multi-cycle restoring divider with valid/ready handshakes
module seq_divider
    import flexibit_div_pkg::*;
#(
    parameter int BITWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] dividend,
    input  logic [BITWIDTH-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] quotient,
    output logic [BITWIDTH-1:0] remainder,
    output logic                div_by_zero
);
    localparam int CW = cnt_w(BITWIDTH);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BITWIDTH:0]   rem_q, rem_d, step_rem;
    logic [BITWIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d;
    logic                dbz_q, dbz_d, step_q;

    // quo_q starts as the dividend and shifts quotient bits in at the LSB
    div_step #(.BITWIDTH(BITWIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[BITWIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dbz_d   = (divisor == '0);
                state_d = dbz_d ? DONE : CALC;
                quo_d   = dbz_d ? '1 : dividend;
                rem_d   = dbz_d ? {1'b0, dividend} : '0;
                dvs_d   = divisor;
                cnt_d   = '0;
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = {quo_q[BITWIDTH-2:0], step_q};
                cnt_d   = (cnt_q == CW'(BITWIDTH - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(BITWIDTH - 1)) ? DONE : CALC;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q[BITWIDTH-1:0];
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against arithmetic division
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic        in_ready, out_valid, div_by_zero;
    logic [15:0] dividend, divisor, quotient, remainder;
    int          tests = 0;
    int          fails = 0;

    seq_divider #(.BITWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency, hold the result for 'hold' cycles, then retire it
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] eq, er;
        int lat;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        chk("in_ready_before", {31'd0, in_ready}, 32'd1);
        dividend = a; divisor = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom); divisor = 16'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (b == 0) ? 32'd1 : 32'd17);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, b == 0});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_quotient", {16'd0, quotient}, {16'd0, eq});
            chk("hold_remainder", {16'd0, remainder}, {16'd0, er});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("retire_in_ready", {31'd0, in_ready}, 32'd1);
        chk("retire_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        do_op(16'd100, 16'd7, 0);
        do_op(16'h1234, 16'd0, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
        do_op(16'd5, 16'd9, 0);
        do_op(16'hFFFF, 16'd1, 0);
        do_op(16'hFFFF, 16'd0, 0);
        do_op(16'h0000, 16'h0003, 0);
        do_op(16'hBEEF, 16'h0013, 10);
        // Reset in the middle of a computation must abandon it without a result
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_quotient", {16'd0, quotient}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                seen += int'(out_valid);
            end
            chk("midreset_no_output", seen, 32'd0);
        end
        for (int n = 0; n < 24; n++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            case (n % 4)
                0: b = 16'($urandom);
                1: b = 16'($urandom_range(1, 20));
                2: b = (n % 8 == 2) ? 16'd0 : 16'($urandom_range(1, 255));
                default: b = 16'($urandom_range(0, 65535));
            endcase
            do_op(a, b, int'($urandom_range(0, 3)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
